// File: rtl/mdu_pkg.sv
// Shared opcodes, state/kind enums, job payload and decode helpers for the MDU controller.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  // MDU opcodes as presented by ID and EX; everything else is a no-op
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;

  // Default busy periods of the multi-cycle jobs
  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  typedef enum logic [1:0] {
    KIND_MULT  = 2'd0,
    KIND_MULTU = 2'd1,
    KIND_DIV   = 2'd2,
    KIND_DIVU  = 2'd3
  } mdu_kind_e;

  // Latched job: operation kind plus both operands
  typedef struct packed {
    mdu_kind_e         kind;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } mdu_job_t;

  // True for the four multi-cycle arithmetic opcodes
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  // True for any opcode that touches the MDU (arith, moves to/from HI/LO)
  function automatic logic is_mdu(input logic [OP_W-1:0] op);
    return (op >= MDU_MULT) && (op <= MDU_MTLO);
  endfunction

  // True for the multiply opcodes (selects the shorter latency)
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  // Map an arithmetic opcode onto the job kind carried by the operand latch
  function automatic mdu_kind_e op_to_kind(input logic [OP_W-1:0] op);
    mdu_kind_e kind;
    kind = KIND_MULT;
    case (op)
      MDU_MULTU: kind = KIND_MULTU;
      MDU_DIV:   kind = KIND_DIV;
      MDU_DIVU:  kind = KIND_DIVU;
      default:   kind = KIND_MULT;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide core; results are sampled by the controller on the commit edge.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_kind_e         op_kind,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              div_zero
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] s_prod;
  logic        [PROD_W-1:0] u_prod;
  logic signed [DATA_W-1:0] s_quo;
  logic signed [DATA_W-1:0] s_rem;
  logic        [DATA_W-1:0] u_quo;
  logic        [DATA_W-1:0] u_rem;
  logic                     b_zero;
  logic                     s_ovf;

  // Products and quotients for every kind; zero divisor and INT_MIN/-1 handled explicitly
  always_comb begin
    b_zero = (b == '0);
    s_ovf  = (a == INT_MIN) && (b == '1);
    s_prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    u_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    s_quo  = '0;
    s_rem  = '0;
    u_quo  = '0;
    u_rem  = '0;
    if (s_ovf) begin
      s_quo = $signed(INT_MIN);
      s_rem = '0;
    end else if (!b_zero) begin
      s_quo = $signed(a) / $signed(b);
      s_rem = $signed(a) % $signed(b);
    end
    if (!b_zero) begin
      u_quo = a / b;
      u_rem = a % b;
    end
  end

  // Route the selected result onto HI/LO and flag a divide by zero
  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op_kind)
      KIND_MULT:  {res_hi, res_lo} = s_prod;
      KIND_MULTU: {res_hi, res_lo} = u_prod;
      KIND_DIV: begin
        res_hi   = s_rem;
        res_lo   = s_quo;
        div_zero = b_zero;
      end
      KIND_DIVU: begin
        res_hi   = u_rem;
        res_lo   = u_quo;
        div_zero = b_zero;
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU issue/sequencing controller: owns HI/LO, times mult/div jobs, serves mfhi/mflo and stalls ID.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic              ex_flush,
  input  logic [OP_W-1:0]   id_op,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W_REQ  = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CNT_W      = (CNT_W_REQ > 4) ? CNT_W_REQ : 4;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_job_t          job_q, job_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              accepted;
  logic              issue_now;
  mdu_job_t          issue_job;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              div_zero;

  // Arithmetic core only ever sees the latched job, never the live EX operands
  mdu_arith u_arith (
    .op_kind  (job_q.kind),
    .a        (job_q.a),
    .b        (job_q.b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // Decode the EX instruction: acceptance, issue of a new job and its payload
  always_comb begin
    accepted       = ex_valid & ~ex_flush;
    issue_now      = accepted & (state_q == IDLE) & is_muldiv(ex_op);
    issue_job.kind = op_to_kind(ex_op);
    issue_job.a    = ex_a;
    issue_job.b    = ex_b;
  end

  // Next-state: issue from IDLE, count down while busy, commit to HI/LO on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    job_d   = job_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (issue_now) begin
          job_d = issue_job;
          if (is_mul(ex_op)) begin
            state_d = MUL;
            cnt_d   = CNT_W'(MUL_CYCLES);
          end else begin
            state_d = DIV;
            cnt_d   = CNT_W'(DIV_CYCLES);
          end
        end else if (accepted && (ex_op == MDU_MTHI)) begin
          hi_d = ex_a;
        end else if (accepted && (ex_op == MDU_MTLO)) begin
          lo_d = ex_a;
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          // A zero divisor still burns the full busy period but leaves HI/LO alone
          if (!div_zero) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, job latch and HI/LO registers; reset discards any in-flight job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      job_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      job_q   <= job_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Busy/stall/read-port outputs; MDU ops arriving while busy are ignored and read as 0
  always_comb begin
    busy    = (state_q != IDLE);
    stall   = reset & is_mdu(id_op) & (busy | issue_now);
    rd_data = '0;
    if (reset && accepted && (state_q == IDLE)) begin
      if (ex_op == MDU_MFHI) begin
        rd_data = hi_q;
      end else if (ex_op == MDU_MFLO) begin
        rd_data = lo_q;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed sequences, a vector table and random traffic vs a reference model.
module tb_mdu_ctrl;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_flush;
  logic [3:0]  id_op;
  logic        stall;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural HI/LO plus the pending job and the cycle it completes
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_ok;
  longint      m_cyc, m_done;

  logic        obs_stall, obs_busy;
  logic [31:0] obs_rd, obs_hi, obs_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_valid (ex_valid),
    .ex_op    (ex_op),
    .ex_a     (ex_a),
    .ex_b     (ex_b),
    .ex_flush (ex_flush),
    .id_op    (id_op),
    .stall    (stall),
    .busy     (busy),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {hi, lo} for an arithmetic op, computed with wide integer arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      la, lb, q, r;
    logic [63:0] res;
    sa  = a;
    sb  = b;
    res = '0;
    case (op)
      OP_MULT: begin
        la  = longint'(sa) * longint'(sb);
        res = la;
      end
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        la  = longint'(sa);
        lb  = longint'(sb);
        q   = la / lb;
        r   = la - q * lb;
        res = {r[31:0], q[31:0]};
      end
      default: begin
        la  = longint'({32'd0, a});
        lb  = longint'({32'd0, b});
        q   = la / lb;
        r   = la % lb;
        res = {r[31:0], q[31:0]};
      end
    endcase
    return res;
  endfunction

  task automatic model_clear();
    m_hi   = '0;
    m_lo   = '0;
    p_ok   = 1'b0;
    m_done = m_cyc;
  endtask

  // One clock: drive at the falling edge, compare 1 ns later, advance the model at the rising edge
  task automatic cycle(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic [3:0] idop);
    bit          exp_busy, acc, issue, exp_stall;
    logic [31:0] exp_rd;
    ex_valid = v;
    ex_op    = op;
    ex_a     = a;
    ex_b     = b;
    ex_flush = fl;
    id_op    = idop;
    #1;
    exp_busy  = reset && (m_cyc < m_done);
    acc       = v && !fl;
    issue     = reset && acc && !exp_busy && (op >= OP_MULT) && (op <= OP_DIVU);
    exp_stall = reset && (idop >= OP_MULT) && (idop <= OP_MTLO) && (exp_busy || issue);
    exp_rd    = '0;
    if (reset && acc && !exp_busy) begin
      if (op == OP_MFHI) exp_rd = m_hi;
      else if (op == OP_MFLO) exp_rd = m_lo;
    end
    obs_stall = stall;
    obs_busy  = busy;
    obs_rd    = rd_data;
    obs_hi    = hi;
    obs_lo    = lo;
    assert (!(reset && obs_busy && acc && (op >= OP_MULT) && (op <= OP_MTLO)))
      else $error("protocol violation: MDU op %0d accepted while busy", op);
    chk("busy", 64'(obs_busy), 64'(exp_busy));
    chk("stall", 64'(obs_stall), 64'(exp_stall));
    chk("rd_data", 64'(obs_rd), 64'(exp_rd));
    chk("hi", 64'(obs_hi), 64'(m_hi));
    chk("lo", 64'(obs_lo), 64'(m_lo));
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else if (exp_busy) begin
      if ((m_cyc + 1 == m_done) && p_ok) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (acc) begin
      if (issue) begin
        {p_hi, p_lo} = ref_result(op, a, b);
        p_ok         = !((op >= OP_DIV) && (b == 32'd0));
        m_done       = m_cyc + 1 + longint'((op <= OP_MULTU) ? MUL_N : DIV_N);
      end else if (op == OP_MTHI) begin
        m_hi = a;
      end else if (op == OP_MTLO) begin
        m_lo = a;
      end
    end
    m_cyc++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] val;
    case ($urandom_range(0, 5))
      0:       val = 32'd0;
      1:       val = 32'hFFFF_FFFF;
      2:       val = 32'h8000_0000;
      3:       val = 32'($urandom_range(0, 20));
      default: val = $urandom;
    endcase
    return val;
  endfunction

  initial begin
    int          stall_n, busy_n, n;
    logic        rv, rfl;
    logic [3:0]  rop, rid;
    logic [31:0] ra, rb, keep_hi, keep_lo;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'h0,    32'h0,    32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0,    32'h0,    32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h0,    32'h0,    32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,    32'h0,    32'hFFFF_FFFE, 32'h0000_0001};
    vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'h0,    32'h0,    32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0,    32'h0,    32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,    32'h0,    32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,         32'h0,    32'h0,    32'h0000_0002, 32'h0000_000E};
    vecs[8]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'h0,    32'h0,    32'h0000_0005, 32'h1999_9999};
    vecs[9]  = '{OP_DIVU,  32'd5,         32'd0,         32'h1234, 32'h5678, 32'h0000_1234, 32'h0000_5678};
    vecs[10] = '{OP_DIV,   32'h8000_0000, 32'd0,         32'hDEAD, 32'hBEEF, 32'h0000_DEAD, 32'h0000_BEEF};
    vecs[11] = '{OP_MULT,  32'd0,         32'd12345,     32'h11,   32'h22,   32'h0000_0000, 32'h0000_0000};

    reset    = 1'b0;
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
    ex_a     = '0;
    ex_b     = '0;
    ex_flush = 1'b0;
    id_op    = OP_NOP;
    m_cyc    = 0;
    p_hi     = '0;
    p_lo     = '0;
    model_clear();
    @(negedge clk);

    // Reset state: outputs held low even with an issuing op in EX and an MDU op in ID
    cycle(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0, OP_MFHI);
    cycle(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0, OP_MFLO);
    reset = 1'b1;

    // mthi then divide by zero: full busy period, HI/LO untouched
    cycle(1'b1, OP_MTHI, 32'h1234, 32'd0, 1'b0, OP_NOP);
    cycle(1'b1, OP_DIV, 32'd5, 32'd0, 1'b0, OP_NOP);
    busy_n = 0;
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_NOP);
      busy_n += int'(obs_busy);
    end
    chk("divzero_busy_cycles", 64'(busy_n), 64'(DIV_N));
    chk("divzero_hi", 64'(obs_hi), 64'h1234);
    chk("divzero_lo", 64'(obs_lo), 64'h0);

    // mtlo, mult back to back, mfhi waiting in ID
    cycle(1'b1, OP_MTLO, 32'h1, 32'd0, 1'b0, OP_MULT);
    chk("mtlo_no_stall", 64'(obs_stall), 64'h0);
    cycle(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0, OP_MFHI);
    stall_n = int'(obs_stall);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_MFHI);
      if (obs_stall) stall_n++;
      else break;
    end
    chk("mult_mfhi_stall_cycles", 64'(stall_n), 64'(MUL_N + 1));
    cycle(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0, OP_NOP);
    chk("mult_mfhi_rd", 64'(obs_rd), 64'h0);
    chk("mult_lo", 64'(obs_lo), 64'd12);

    // divu with mflo in ID during the issue cycle
    cycle(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, OP_MFLO);
    stall_n = int'(obs_stall);
    busy_n  = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_MFLO);
      busy_n += int'(obs_busy);
      if (obs_stall) stall_n++;
      else break;
    end
    chk("divu_stall_cycles", 64'(stall_n), 64'(DIV_N + 1));
    chk("divu_busy_cycles", 64'(busy_n), 64'(DIV_N));
    cycle(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0, OP_NOP);
    chk("divu_mflo_rd", 64'(obs_rd), 64'd14);
    chk("divu_hi", 64'(obs_hi), 64'd2);

    // Flushed multu: nothing issues, nothing stalls
    keep_hi = obs_hi;
    keep_lo = obs_lo;
    cycle(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, OP_MFHI);
    chk("flush_stall", 64'(obs_stall), 64'h0);
    busy_n = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_NOP);
      busy_n += int'(obs_busy);
    end
    chk("flush_busy_cycles", 64'(busy_n), 64'h0);
    chk("flush_hi", 64'(obs_hi), 64'(keep_hi));
    chk("flush_lo", 64'(obs_lo), 64'(keep_lo));

    // Reset asserted mid-divide on the third busy cycle
    cycle(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, OP_NOP);
    cycle(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_NOP);
    cycle(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_NOP);
    ex_valid = 1'b0;
    ex_op    = OP_MFHI;
    id_op    = OP_MFLO;
    #1;
    chk("pre_reset_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy), 64'h0);
    chk("async_reset_hi", 64'(hi), 64'h0);
    chk("async_reset_lo", 64'(lo), 64'h0);
    chk("async_reset_stall", 64'(stall), 64'h0);
    model_clear();
    @(posedge clk);
    m_cyc++;
    @(negedge clk);
    cycle(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0, OP_MFLO);
    reset = 1'b1;
    cycle(1'b1, OP_MTLO, 32'hA5, 32'd0, 1'b0, OP_MFLO);
    chk("post_reset_mtlo_stall", 64'(obs_stall), 64'h0);
    cycle(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0, OP_NOP);
    chk("post_reset_mflo_rd", 64'(obs_rd), 64'hA5);
    chk("post_reset_mflo_stall", 64'(obs_stall), 64'h0);

    // Vector table: preload HI/LO, run one job with an MDU op held in ID
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, OP_MTHI, vecs[i].pre_hi, 32'd0, 1'b0, OP_NOP);
      cycle(1'b1, OP_MTLO, vecs[i].pre_lo, 32'd0, 1'b0, OP_NOP);
      cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, OP_MFHI);
      n       = (vecs[i].op <= OP_MULTU) ? int'(MUL_N) : int'(DIV_N);
      stall_n = int'(obs_stall);
      busy_n  = 0;
      for (int k = 0; k < n + 2; k++) begin
        cycle(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_MFHI);
        busy_n  += int'(obs_busy);
        stall_n += int'(obs_stall);
      end
      chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(n));
      chk($sformatf("vec%0d_stall_cycles", i), 64'(stall_n), 64'(n + 1));
      chk($sformatf("vec%0d_hi", i), 64'(obs_hi), 64'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_lo", i), 64'(obs_lo), 64'(vecs[i].exp_lo));
    end

    // Random traffic that respects the no-issue-while-busy protocol
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rop = 4'($urandom_range(0, 15));
      rfl = ($urandom_range(0, 7) == 0);
      rid = 4'($urandom_range(0, 15));
      ra  = pick_operand();
      rb  = pick_operand();
      if ((m_cyc < m_done) && rv && !rfl && (rop >= OP_MULT) && (rop <= OP_MTLO)) rop = OP_NOP;
      cycle(rv, rop, ra, rb, rfl, rid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
